// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, two selectable baud rates.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int unsigned          T_DIV_BIT = 4,
  parameter logic [T_DIV_BIT-1:0] T_DIV_0   = T_DIV_BIT'(15),
  parameter logic [T_DIV_BIT-1:0] T_DIV_1   = T_DIV_BIT'(7)
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       baudrate,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned DATA_W    = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [T_DIV_BIT-1:0]   div_q, div_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic                   rate_q, rate_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   bit_end_c;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  // Last clock of the current bit period at the latched rate
  assign bit_end_c = (div_q == (rate_q ? T_DIV_1 : T_DIV_0));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rate_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rate_q  <= rate_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic; tx_d always carries the line level of the next cycle
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    rate_d  = rate_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE && !bit_end_c) begin
      div_d = div_q + T_DIV_BIT'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          state_d = S_START;
          shift_d = tx_data;
          rate_d  = baudrate;
          bit_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          if (bit_q == BIT_CNT_W'(7)) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + BIT_CNT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_c) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end_c) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model, literal frame
// patterns, behavioural loopback receiver and randomized traffic.
module tb_uart_tx;

  localparam int CLK_P = 10;
  localparam int T0    = 15;
  localparam int T1    = 7;

`ifdef UART_TX_PARITY_EN
  localparam int          NB     = 11;
  localparam logic [10:0] PAT_C5 = 11'b101_1000_1010;
  localparam logic [10:0] PAT_C6 = 11'b101_1000_1100;
  localparam logic [10:0] PAT_A5 = 11'b101_0100_1010;
  localparam logic [10:0] PAT_C4 = 11'b111_1000_1000;
  localparam int          DONE0  = 176;
  localparam int          DONE1  = 88;
`else
  localparam int          NB     = 10;
  localparam logic [10:0] PAT_C5 = 11'b011_1000_1010;
  localparam logic [10:0] PAT_C6 = 11'b011_1000_1100;
  localparam logic [10:0] PAT_A5 = 11'b011_0100_1010;
  localparam int          DONE0  = 160;
  localparam int          DONE1  = 80;
`endif

  logic       clk, n_rst, baudrate, tx_start;
  logic [7:0] tx_data;
  logic       tx, tx_busy, tx_done;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  uart_tx #(.T_DIV_BIT(4), .T_DIV_0(4'd15), .T_DIV_1(4'd7)) dut (
    .clk(clk), .n_rst(n_rst), .baudrate(baudrate), .tx_start(tx_start),
    .tx_data(tx_data), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #(CLK_P/2) clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Line levels of one frame, slot 0 = start bit
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  // Reference model: m_cnt = clocks since acceptance (0 when idle)
  int          m_cnt = 0;
  int          m_per = T0 + 1;
  int          acc_cnt = 0;
  logic [10:0] m_bits = '1;
  logic        m_done = 1'b0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (tx_start) begin
          m_bits  <= frame_bits(tx_data);
          m_per   <= baudrate ? T1 + 1 : T0 + 1;
          m_cnt   <= 1;
          acc_cnt <= acc_cnt + 1;
        end
      end else if (m_cnt == NB * m_per) begin
        m_cnt  <= 0;
        m_done <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst && chk_en) begin
      chk("cyc_tx", 32'(tx), (m_cnt != 0) ? 32'(m_bits[(m_cnt-1)/m_per]) : 32'd1);
      chk("cyc_busy", 32'(tx_busy), (m_cnt != 0) ? 32'd1 : 32'd0);
      chk("cyc_done", 32'(tx_done), 32'(m_done));
    end
  end

  // One frame with literal slot levels and tx_done clock; optional mid-frame
  // request injection (inj) or reset (rst_at), both counted in clocks.
  task automatic frame(input logic [7:0] d, input logic b, input logic [10:0] exp,
                       input int p, input int done_lit, input int inj,
                       input int rst_at, input string tag);
    int ndone, done_c;
    ndone  = 0;
    done_c = -1;
    @(posedge clk); #1;
    tx_data = d; baudrate = b; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    for (int c = 1; c <= NB * p + 30; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        #2 n_rst = 1'b0;
        #1;
        chk({tag, "_rst_tx"}, 32'(tx), 32'd1);
        chk({tag, "_rst_busy"}, 32'(tx_busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk({tag, "_rst_no_done"}, 32'(tx_done), 32'd0);
        end
        @(posedge clk); #1 n_rst = 1'b1;
        return;
      end
      if (c == inj) begin
        tx_start = 1'b1; tx_data = 8'h3C; baudrate = ~b;
      end
      if (c == inj + 1) begin
        tx_start = 1'b0; baudrate = b;
      end
      if (c <= NB * p && (c % p) == p / 2)
        chk({tag, "_slot"}, 32'(tx), 32'(exp[c/p]));
      if (tx_done) begin
        ndone++;
        done_c = c - 1;
      end
    end
    chk({tag, "_done_count"}, 32'(ndone), 32'd1);
    chk({tag, "_done_clock"}, 32'(done_c), 32'(done_lit));
  endtask

  task automatic lb_tx();
    int prev, n;
    for (int k = 0; k < 4; k++) begin
      tx_data  = 8'(8'hC5 + k);
      tx_start = 1'b1;
      prev = acc_cnt;
      n = 0;
      while (acc_cnt == prev && n < 2000) begin
        @(posedge clk); #1;
        n++;
      end
      chk("lb_accept", 32'(acc_cnt), 32'(prev + 1));
    end
    tx_start = 1'b0;
  endtask

  // Behavioural receiver: mid-bit sampling of the serial line
  task automatic lb_rx(input int p);
    logic [7:0] got;
    longint     t_prev, t_now, gap;
    int         n;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (tx !== 1'b0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("lb_start_edge", 32'(tx), 32'd0);
      t_now = $time;
      if (k > 0) begin
        gap = (t_now - t_prev) / CLK_P;
        n_chk++;
        if (gap < NB * p || gap >= (NB + 1) * p) begin
          n_fail++;
          $display("FAIL lb_frame_spacing: got %0d clocks, required %0d..%0d", gap, NB * p, (NB + 1) * p - 1);
        end
      end
      repeat (p / 2) @(negedge clk);
      chk("lb_start_mid", 32'(tx), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (p) @(negedge clk);
        got[i] = tx;
      end
`ifdef UART_TX_PARITY_EN
      repeat (p) @(negedge clk);
      chk("lb_parity", 32'(tx), 32'(^got));
`endif
      repeat (p) @(negedge clk);
      chk("lb_stop", 32'(tx), 32'd1);
      chk("lb_data", 32'(got), 32'(8'(8'hC5 + k)));
      t_prev = t_now;
    end
  endtask

  initial begin
    n_rst = 1'b0; tx_start = 1'b0; tx_data = 8'h00; baudrate = 1'b0;
    #22;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    chk("reset_done", 32'(tx_done), 32'd0);
    n_rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);

    frame(8'hC5, 1'b0, PAT_C5, T0 + 1, DONE0, 0, 0, "c5_b0");
    frame(8'hC6, 1'b1, PAT_C6, T1 + 1, DONE1, 0, 0, "c6_b1");

    @(posedge clk); #1;
    baudrate = 1'b0;
    fork
      lb_tx();
      lb_rx(T0 + 1);
    join
    repeat (20) @(posedge clk);

    frame(8'hC5, 1'b0, PAT_C5, T0 + 1, DONE0, 40, 0, "c5_inject");
    frame(8'hC5, 1'b0, PAT_C5, T0 + 1, DONE0, 0, 70, "c5_reset");
    frame(8'hA5, 1'b0, PAT_A5, T0 + 1, DONE0, 0, 0, "a5_after_rst");
`ifdef UART_TX_PARITY_EN
    frame(8'hC4, 1'b0, PAT_C4, T0 + 1, DONE0, 0, 0, "c4_parity");
`endif

    // Random requests, pulses and levels, many ignored while busy
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      tx_start = ($urandom_range(0, 7) == 0);
      tx_data  = 8'($urandom);
      baudrate = 1'($urandom);
    end
    tx_start = 1'b0;
    repeat (NB * (T0 + 1) + 20) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
